// File: rtl/clk_gen_pkg.sv
// Shared definitions for the multi-channel clock generator.
//   ch_state_t : per-channel state (RUN, DRAIN, HALT, STEP)
//   ch_width() : width of a channel index, never less than one bit
package clk_gen_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2,
    ST_STEP  = 2'd3
  } ch_state_t;

  function automatic int ch_width(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/clk_gen_multi_if.sv
// Divide-value write bus for clk_gen_multi.
//   wr_en  : write strobe
//   wr_ch  : addressed channel
//   wr_div : new divide value (half-period = wr_div+1 sysclk cycles)
// master drives the bus, slave (the clock generator) receives it.
interface clk_gen_multi_if #(
  parameter int CH_W  = 2,
  parameter int CNT_W = 8
);
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_div;

  modport master (output wr_en, output wr_ch, output wr_div);
  modport slave  (input  wr_en, input  wr_ch, input  wr_div);
endinterface

// File: rtl/clk_gen_channel.sv
// One divided-clock channel.
//   sysclk  : system clock
//   reset   : synchronous active-high reset
//   run     : 1 = run, 0 = halt request (glitch-free, parks low)
//   step    : single-step request, honoured only while halted
//   wr_hit  : this channel is addressed by a divide-value write
//   wr_div  : value written into the pending divide register
//   clk_out : divided clock, half-period = active_div+1 cycles
//   clk_en  : one-cycle pulse coincident with each clk_out rise
//   halted  : 1 while the channel sits in HALT (one cycle late)
module clk_gen_channel
  import clk_gen_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 50,
  parameter bit START_RUN   = 1'b1
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             wr_hit,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clk_out,
  output logic             clk_en,
  output logic             halted
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  ch_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active_div;
  logic [CNT_W-1:0] pending_div;

  logic toggle;
  logic fall;

  assign toggle = (cnt == active_div);
  assign fall   = toggle & clk_out;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state       <= START_RUN ? ST_RUN : ST_HALT;
      cnt         <= '0;
      clk_out     <= 1'b0;
      clk_en      <= 1'b0;
      active_div  <= DIV_RST;
      pending_div <= DIV_RST;
      halted      <= ~START_RUN;
    end else begin
      clk_en <= 1'b0;
      halted <= (state == ST_HALT);

      // A boundary in this same cycle still loads the old pending value
      // below, because the non-blocking write lands afterwards.
      if (wr_hit) begin
        pending_div <= wr_div;
      end

      if (state == ST_HALT) begin
        // Parked low with cnt=0; keep the divider fresh so the first
        // period after leaving HALT uses the latest written value.
        active_div <= pending_div;
        if (run) begin
          state <= ST_RUN;
        end else if (step) begin
          state <= ST_STEP;
        end
      end else begin
        // Common counting for RUN, DRAIN and STEP.
        if (toggle) begin
          cnt        <= '0;
          clk_out    <= ~clk_out;
          clk_en     <= ~clk_out;
          active_div <= pending_div;
        end else begin
          cnt <= cnt + 1'b1;
        end

        case (state)
          ST_RUN: begin
            if (!run) begin
              if (!clk_out) begin
                // Already low: park now and suppress a rise that may be due.
                state   <= ST_HALT;
                cnt     <= '0;
                clk_out <= 1'b0;
                clk_en  <= 1'b0;
              end else if (fall) begin
                // Falling this very cycle: no high phase left to drain.
                state <= ST_HALT;
              end else begin
                state <= ST_DRAIN;
              end
            end
          end
          ST_DRAIN, ST_STEP: begin
            if (run) begin
              state <= ST_RUN;
            end else if (fall) begin
              state <= ST_HALT;
            end
          end
          default: state <= ST_HALT;
        endcase
      end
    end
  end

endmodule

// File: rtl/clk_gen_multi.sv
// NUM_CH independent divided-clock channels from sysclk.
//   sysclk  : system clock, all logic on posedge
//   reset   : synchronous active-high reset
//   run     : per-channel run level (0 = halt request)
//   step    : per-channel single-step pulse
//   wr      : divide-value write bus (slave side)
//   clk_out : per-channel divided clock, 50% duty
//   clk_en  : per-channel pulse on each clk_out rise
//   halted  : per-channel HALT indication
// The top only decodes the write address; writes to a channel index
// at or above NUM_CH match no channel and are dropped.
module clk_gen_multi
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 50,
  parameter bit START_RUN   = 1'b1,
  localparam int CH_W       = ch_width(NUM_CH)
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] run,
  input  logic [NUM_CH-1:0] step,
  clk_gen_multi_if.slave    wr,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] halted
);

  logic [NUM_CH-1:0] wr_hit;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign wr_hit[gi] = wr.wr_en && (wr.wr_ch == CH_W'(gi));

      clk_gen_channel #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV),
        .START_RUN   (START_RUN)
      ) u_channel (
        .sysclk  (sysclk),
        .reset   (reset),
        .run     (run[gi]),
        .step    (step[gi]),
        .wr_hit  (wr_hit[gi]),
        .wr_div  (wr.wr_div),
        .clk_out (clk_out[gi]),
        .clk_en  (clk_en[gi]),
        .halted  (halted[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_gen_multi.sv
// Self-checking bench for clk_gen_multi. Three channels are built so that
// channel index 3 is representable on the 2-bit write address but does not
// exist. A countdown-based reference model predicts every output each cycle;
// directed timing measurements back it up.
module tb_clk_gen_multi;
  localparam int NCH   = 3;
  localparam int CNT_W = 8;
  localparam int DEF   = 50;
  localparam int CH_W  = 2;

  localparam int M_RUNNING  = 0;
  localparam int M_STOPPING = 1;
  localparam int M_PARKED   = 2;
  localparam int M_SINGLE   = 3;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  logic [NCH-1:0] run  = '1;
  logic [NCH-1:0] step = '0;
  logic [NCH-1:0] clk_out, clk_en, halted;

  clk_gen_multi_if #(.CH_W(CH_W), .CNT_W(CNT_W)) wr_bus ();

  clk_gen_multi #(
    .NUM_CH(NCH), .CNT_W(CNT_W), .DEFAULT_DIV(DEF), .START_RUN(1'b1)
  ) dut (
    .sysclk(sysclk), .reset(reset), .run(run), .step(step), .wr(wr_bus),
    .clk_out(clk_out), .clk_en(clk_en), .halted(halted)
  );

  always #5 sysclk = ~sysclk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: level, edges remaining until next toggle, mode.
  int m_lvl[NCH], m_en[NCH], m_rem[NCH], m_pend[NCH], m_halt[NCH], m_mode[NCH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      if (reset) begin
        m_lvl[c] = 0; m_en[c] = 0; m_pend[c] = DEF; m_rem[c] = DEF + 1;
        m_mode[c] = M_RUNNING; m_halt[c] = 0;
      end else begin
        int was_parked;
        was_parked = (m_mode[c] == M_PARKED);
        m_en[c] = 0;
        if (was_parked) begin
          m_rem[c] = m_pend[c] + 1;
          if (run[c]) m_mode[c] = M_RUNNING;
          else if (step[c]) m_mode[c] = M_SINGLE;
        end else if (m_mode[c] == M_RUNNING && !run[c] && m_lvl[c] == 0) begin
          m_mode[c] = M_PARKED;
        end else begin
          int bd, prev;
          bd = (m_rem[c] == 1);
          prev = m_lvl[c];
          if (bd) begin
            m_lvl[c] = 1 - m_lvl[c];
            m_en[c] = m_lvl[c];
            m_rem[c] = m_pend[c] + 1;
          end else begin
            m_rem[c] = m_rem[c] - 1;
          end
          if (run[c]) m_mode[c] = M_RUNNING;
          else if (bd && prev == 1) m_mode[c] = M_PARKED;
          else if (m_mode[c] == M_RUNNING) m_mode[c] = M_STOPPING;
        end
        m_halt[c] = was_parked;
        if (wr_bus.wr_en && int'(wr_bus.wr_ch) == c) m_pend[c] = int'(wr_bus.wr_div);
      end
    end
  endtask

  // Advance one sysclk cycle and compare every output with the model.
  task automatic tick();
    logic [NCH-1:0] e_out, e_en, e_halt;
    model_step();
    @(posedge sysclk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      e_out[c] = m_lvl[c][0];
      e_en[c] = m_en[c][0];
      e_halt[c] = m_halt[c][0];
    end
    check("clk_out", 32'(clk_out), 32'(e_out));
    check("clk_en", 32'(clk_en), 32'(e_en));
    check("halted", 32'(halted), 32'(e_halt));
  endtask

  task automatic write_div(input int ch, input int div);
    wr_bus.wr_en = 1'b1;
    wr_bus.wr_ch = CH_W'(ch);
    wr_bus.wr_div = CNT_W'(div);
    tick();
    wr_bus.wr_en = 1'b0;
  endtask

  // Count cycles until clk_out[ch] reaches the given level (bounded).
  task automatic cycles_until(input int ch, input logic lvl, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (clk_out[ch] !== lvl && n < 400);
  endtask

  task automatic reset_and_measure();
    int n;
    reset = 1'b1;
    tick();
    check("rst_clk_out", 32'(clk_out), 32'd0);
    reset = 1'b0;
    cycles_until(0, 1'b1, n);
    check("first_rise", n, 51);
    check("first_en", 32'(clk_en[0]), 32'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (clk_en[0] !== 1'b1 && n < 400);
    check("period", n, 102);
  endtask

  initial begin
    int n;
    wr_bus.wr_en = 1'b0;
    wr_bus.wr_ch = '0;
    wr_bus.wr_div = '0;
    run = '1;

    // Defaults after reset: first rise and period on channel 0.
    reset_and_measure();

    // Channel 2 to div 0 while halted, then run: toggles every cycle.
    run[2] = 1'b0;
    cycles_until(2, 1'b0, n);
    tick();
    write_div(2, 0);
    tick();
    run[2] = 1'b1;
    for (int i = 0; i < 8; i++) tick();

    // Channel 1: div 3, halt, single step with a redundant step during STEP.
    write_div(1, 3);
    run[1] = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (halted[1] !== 1'b1 && n < 400);
    check("ch1_halted", 32'(halted[1]), 32'd1);
    step[1] = 1'b1;
    tick();
    step[1] = 1'b0;
    cycles_until(1, 1'b1, n);
    check("step_rise", n, 4);
    step[1] = 1'b1;
    tick();
    step[1] = 1'b0;
    cycles_until(1, 1'b0, n);
    check("step_fall", n + 1, 4);
    for (int i = 0; i < 12; i++) tick();
    check("step_parked", 32'(clk_out[1]), 32'd0);

    // Channel 1 running div 3, drop run one cycle into the high phase.
    run[1] = 1'b1;
    cycles_until(1, 1'b1, n);
    tick();
    run[1] = 1'b0;
    cycles_until(1, 1'b0, n);
    check("drain_len", n, 3);
    tick();
    check("drain_halted", 32'(halted[1]), 32'd1);

    // Channel 0 div 3, rewritten to 1 mid-phase; invalid address ignored.
    write_div(0, 3);
    for (int i = 0; i < 110; i++) tick();
    write_div(3, 0);
    write_div(0, 1);
    for (int i = 0; i < 20; i++) tick();

    // Randomized traffic.
    for (int c = 0; c < NCH; c++) write_div(c, $urandom_range(0, 5));
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 39) == 0) run[c] = ~run[c];
        step[c] = ($urandom_range(0, 24) == 0);
      end
      wr_bus.wr_en = ($urandom_range(0, 9) == 0);
      wr_bus.wr_ch = CH_W'($urandom_range(0, 3));
      wr_bus.wr_div = CNT_W'($urandom_range(0, 6));
      tick();
    end
    step = '0;
    wr_bus.wr_en = 1'b0;
    run = '1;

    // Reset while channel 0 is high, then the reset timing repeats.
    write_div(0, 4);
    cycles_until(0, 1'b1, n);
    tick();
    check("pre_reset_high", 32'(clk_out[0]), 32'd1);
    reset_and_measure();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
